// File: rtl/state_reg_dwell_pkg.sv
// Shared constants for the vending-machine state register: default sizes and the state encoding.
package state_reg_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_DWELL_W     = 8;
    localparam int DEF_TIMEOUT_CYC = 200;

    // Controller state encoding, used for RESET_STATE and as next-state values.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        COIN     = 4'd1,
        SELECT   = 4'd2,
        DISPENSE = 4'd3,
        REFUND   = 4'd4
    } vm_state_e;

endpackage

// File: rtl/state_reg_dwell_sat_counter.sv
// Saturating up-counter with a synchronous zero and an all-ones flag; never wraps.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         zero,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         all_ones
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    assign all_ones = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (zero) begin
            count <= '0;
        end else if (inc && !all_ones) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/state_reg_dwell.sv
// Current-state register with previous-state capture, change pulse and dwell counter.
// Optional one-shot dwell timeout is built only when STATE_REG_TIMEOUT_EN is defined.
module state_reg_dwell
    import state_reg_pkg::*;
#(
    parameter int                 WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_STATE = WIDTH'(IDLE),
    parameter int                 DWELL_W     = DEF_DWELL_W,
    parameter int                 TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [WIDTH-1:0]   ns,
    output logic [WIDTH-1:0]   cs,
    output logic [WIDTH-1:0]   ps,
    output logic               changed,
    output logic [DWELL_W-1:0] dwell,
    output logic               dwell_sat,
    output logic               timeout
);

    logic             load;
    logic [WIDTH-1:0] next_cs;
    logic             cs_change;

    // Clear wins over enable; a load of the current value is not a change.
    always_comb begin
        load      = clr | en;
        next_cs   = clr ? RESET_STATE : ns;
        cs_change = load && (next_cs != cs);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs      <= RESET_STATE;
            ps      <= RESET_STATE;
            changed <= 1'b0;
        end else begin
            changed <= cs_change;
            if (load) begin
                cs <= next_cs;
                ps <= cs;
            end
        end
    end

    sat_counter #(
        .W(DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .zero     (cs_change),
        .inc      (1'b1),
        .count    (dwell),
        .all_ones (dwell_sat)
    );

`ifdef STATE_REG_TIMEOUT_EN
    localparam logic [DWELL_W-1:0] TIMEOUT_PRE = DWELL_W'(TIMEOUT_CYC - 1);

    // The count passes TIMEOUT_CYC-1 only once per dwell period, so this cannot re-fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= !cs_change && (dwell == TIMEOUT_PRE);
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_state_reg_dwell.sv
// Scoreboard bench for state_reg_dwell: a behavioural model queues expected outputs, a monitor compares.
// Two instances share stimulus: an 8-bit dwell counter and a 3-bit one for saturation.
module tb_state_reg_dwell;
    import state_reg_pkg::*;

    localparam int              TO_CYC = 5;
    localparam logic [3:0]      RST_ST = IDLE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] ns;
    logic [3:0] cs, ps, cs_s, ps_s;
    logic       changed, changed_s;
    logic [7:0] dwell;
    logic [2:0] dwell_s;
    logic       dwell_sat, dwell_sat_s;
    logic       timeout, timeout_s;

    always #5 clk = ~clk;

`ifdef STATE_REG_TIMEOUT_EN
    if (TO_CYC < 1 || TO_CYC > 7) begin : g_to_range
        $error("[TB] TIMEOUT_CYC outside the range of the dwell counters");
    end
`endif

    state_reg_dwell #(
        .WIDTH(4), .RESET_STATE(RST_ST), .DWELL_W(8), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ns(ns),
        .cs(cs), .ps(ps), .changed(changed), .dwell(dwell),
        .dwell_sat(dwell_sat), .timeout(timeout)
    );

    state_reg_dwell #(
        .WIDTH(4), .RESET_STATE(RST_ST), .DWELL_W(3), .TIMEOUT_CYC(TO_CYC)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ns(ns),
        .cs(cs_s), .ps(ps_s), .changed(changed_s), .dwell(dwell_s),
        .dwell_sat(dwell_sat_s), .timeout(timeout_s)
    );

    typedef struct {
        string      name;
        logic [3:0] cs;
        logic [3:0] ps;
        logic       changed;
        logic [7:0] dwell;
        logic       sat;
        logic [2:0] dwell_s;
        logic       sat_s;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    event async_ev;

    logic [3:0] m_cs, m_ps;
    logic       m_chg, m_to;
    int         m_dwell;

    function automatic void modelReset();
        m_cs    = RST_ST;
        m_ps    = RST_ST;
        m_chg   = 1'b0;
        m_to    = 1'b0;
        m_dwell = 0;
    endfunction

    function automatic void pushExpected(input string name);
        exp_t e;
        e.name    = name;
        e.cs      = m_cs;
        e.ps      = m_ps;
        e.changed = m_chg;
        e.dwell   = (m_dwell >= 255) ? 8'hFF : 8'(m_dwell);
        e.sat     = (m_dwell >= 255);
        e.dwell_s = (m_dwell >= 7) ? 3'h7 : 3'(m_dwell);
        e.sat_s   = (m_dwell >= 7);
`ifdef STATE_REG_TIMEOUT_EN
        e.timeout = m_to;
`else
        e.timeout = 1'b0;
`endif
        exp_q.push_back(e);
    endfunction

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // One clock edge of stimulus; the model result for that edge is queued just after it.
    task automatic applyStimulus(input logic en_v, input logic clr_v,
                                 input logic [3:0] ns_v, input string name);
        en  = en_v;
        clr = clr_v;
        ns  = ns_v;
        @(posedge clk);
        if (clr_v) begin
            m_chg = (m_cs != RST_ST);
            m_ps  = m_cs;
            m_cs  = RST_ST;
        end else if (en_v) begin
            m_chg = (ns_v != m_cs);
            m_ps  = m_cs;
            m_cs  = ns_v;
        end else begin
            m_chg = 1'b0;
        end
        m_dwell = m_chg ? 0 : m_dwell + 1;
        m_to    = !m_chg && (m_dwell == TO_CYC);
        pushExpected(name);
        #1;
    endtask

    // Monitor: compares on the falling edge, or immediately when an async check is requested.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or async_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput({e.name, ".cs"},        32'(cs),          32'(e.cs));
                checkOutput({e.name, ".ps"},        32'(ps),          32'(e.ps));
                checkOutput({e.name, ".changed"},   32'(changed),     32'(e.changed));
                checkOutput({e.name, ".dwell"},     32'(dwell),       32'(e.dwell));
                checkOutput({e.name, ".dwell_sat"}, 32'(dwell_sat),   32'(e.sat));
                checkOutput({e.name, ".timeout"},   32'(timeout),     32'(e.timeout));
                checkOutput({e.name, ".dwell3"},    32'(dwell_s),     32'(e.dwell_s));
                checkOutput({e.name, ".sat3"},      32'(dwell_sat_s), 32'(e.sat_s));
                checkOutput({e.name, ".timeout3"},  32'(timeout_s),   32'(e.timeout));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        ns    = 4'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        pushExpected("reset_init");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 4'h5, "load5");
        repeat (10) applyStimulus(1'b1, 1'b0, 4'h5, "same_load");
        applyStimulus(1'b0, 1'b0, 4'hA, "ns_ignored");

        applyStimulus(1'b1, 1'b0, SELECT, "load_select");
        applyStimulus(1'b1, 1'b1, 4'h7, "clr_priority");
        applyStimulus(1'b0, 1'b1, 4'h0, "clr_no_change");

        applyStimulus(1'b1, 1'b0, REFUND, "load_refund");
        for (int i = 0; i < 260; i++) applyStimulus(1'b0, 1'b0, 4'h0, "hold_sat");

        applyStimulus(1'b1, 1'b0, COIN, "load_coin");
        repeat (4) applyStimulus(1'b0, 1'b0, 4'h0, "hold_pre_to");
        applyStimulus(1'b1, 1'b0, SELECT, "change_at_to");
        repeat (6) applyStimulus(1'b0, 1'b0, 4'h0, "hold_to");

        // Reset dropped between edges after a 17-cycle dwell in DISPENSE.
        applyStimulus(1'b1, 1'b0, DISPENSE, "load_dispense");
        repeat (17) applyStimulus(1'b0, 1'b0, 4'h0, "hold_17");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        modelReset();
        pushExpected("async_reset");
        #1;
        -> async_ev;
        @(posedge clk);
        #1;
        pushExpected("reset_held");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) applyStimulus(1'b0, 1'b0, 4'h0, "hold_after_reset");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/state_reg_dwell.md
# state_reg_dwell

Parametrised state register for the vending-machine controller, generalising the single-bit D flip-flop into a WIDTH-bit current-state register. Adds load enable, synchronous clear, previous-state capture, a change pulse, and a saturating dwell counter of cycles spent in the current state. Sits between the next-state logic and the output decoder, and gives the controller the timing it needs for coin-wait and dispense timeouts.

## Interface
Parameters:
- WIDTH, 4, state vector width (≥1)
- RESET_STATE, 0, value of CS/PS after reset or CLR (WIDTH bits)
- DWELL_W, 8, dwell counter width (≥2)
- TIMEOUT_CYC, 200, dwell value that fires TIMEOUT (1 ≤ TIMEOUT_CYC ≤ 2^DWELL_W−1; only used with the timeout macro)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  reset, asynchronous, active-low
- EN  in  1  load enable for NS
- CLR  in  1  synchronous clear to RESET_STATE; overrides EN
- NS  in  WIDTH  next state
- CS  out  WIDTH  current state (registered)
- PS  out  WIDTH  state held before the most recent load/clear
- CHANGED  out  1  one-cycle pulse: the last edge changed CS
- DWELL  out  DWELL_W  cycles CS has been unchanged, saturating
- DWELL_SAT  out  1  DWELL is all ones (combinational from DWELL)
- TIMEOUT  out  1  one-cycle pulse (timeout macro only; tied 0 otherwise)

## Operation
- Reset (RST_N=0, any time, no clock needed): CS=PS=RESET_STATE, CHANGED=0, DWELL=0, TIMEOUT=0. Release is synchronous to the next edge. The first active edge sees RST_N=1.
- Per rising edge, priority CLR > EN > hold:
  - CLR=1: CS←RESET_STATE. PS←CS. CHANGED←(CS≠RESET_STATE). DWELL←0 if CS changed, else increment.
  - EN=1, CLR=0: CS←NS. PS←CS. CHANGED←(NS≠CS). DWELL←0 if NS≠CS, else increment.
  - EN=0, CLR=0: CS and PS hold. CHANGED←0. DWELL increments.
- Increment means DWELL+1, saturating at 2^DWELL_W−1. The counter never wraps.
- Loading NS equal to CS updates PS (PS←CS, which makes PS=CS). It counts as no change: CHANGED=0 and the dwell continues.
- NS is ignored entirely while EN=0.

## Timing
- Latency 1 cycle: NS sampled at edge k appears on CS after edge k. CHANGED and DWELL=0 appear in the same cycle.
- CHANGED is never high for two consecutive cycles unless CS changes on consecutive edges.
- DWELL=n means CS has been stable across n edges since the last change, reset or clear.
- Reset asserted mid-dwell discards the count. No TIMEOUT fires during or right after reset.

## Configuration
- Macro STATE_REG_TIMEOUT_EN.
- Defined: TIMEOUT pulses high for exactly one cycle, on the edge where DWELL goes from TIMEOUT_CYC−1 to TIMEOUT_CYC. It fires once per dwell period; saturation or a held DWELL does not re-fire it. A state change on that same edge suppresses the pulse. The bench checks the TIMEOUT_CYC range at elaboration.
- Undefined: TIMEOUT is a constant 0 and no compare logic is built.
- All other behaviour is identical either way.

## Structure
- Package state_reg_pkg holds:
  - default WIDTH/DWELL_W/TIMEOUT_CYC constants
  - the vending-machine state encoding constants (IDLE, COIN, SELECT, DISPENSE, REFUND) used as RESET_STATE and NS values
- One sub-module, sat_counter (parameter W): synchronous zero, increment, saturate, and an all-ones flag. The dwell counter is an instance of it.
- Register and change logic stays in state_reg_dwell.

## Test plan
- Reset: RST_N=0 asynchronously mid-cycle with CS=4'h3, DWELL=17 -> CS=PS=RESET_STATE, DWELL=0, CHANGED=0 immediately, without waiting for an edge.
- Load: CS=0, EN=1, NS=4'h5 at one edge -> next cycle CS=5, PS=0, CHANGED=1, DWELL=0. One more edge with EN=0 -> CHANGED=0, DWELL=1.
- Same-value load and hold: EN=1, NS=CS for 10 edges -> CHANGED stays 0, DWELL=10, PS=CS.
- CLR priority: CS=4'h2, CLR=1 and EN=1 with NS=4'h7 -> CS=RESET_STATE, PS=2, CHANGED=1. NS is ignored.
- Saturation: DWELL_W=3, hold 12 edges -> DWELL stops at 7, DWELL_SAT=1 from the 7th edge onward, no wrap.
- Timeout (macro defined, TIMEOUT_CYC=5): hold -> TIMEOUT high only in the cycle DWELL=5. Change state at edge 5 -> no pulse. Macro undefined -> TIMEOUT constantly 0.
